// File: rtl/stacked_regfile_pkg.sv
// rtl/stacked_regfile_pkg.sv - shared constants and types for the integer register file
// Optional feature macro: STACKED_REGFILE_WRITE_BYPASS_EN (write-to-read forwarding)
package stacked_regfile_pkg;

   localparam int WIDTH_C  = 32;
   localparam int ADDR_W_C = 5;
   localparam int NREGS_C  = 2 ** ADDR_W_C;

   typedef logic [WIDTH_C-1:0]  reg_t;
   typedef logic [ADDR_W_C-1:0] addr_t;

   // Register x0 is hardwired to zero in the RISC-V integer file
   function automatic logic is_x0(input addr_t addr);
      return (addr == '0);
   endfunction

endpackage

// File: rtl/stacked_regfile_rdport.sv
// rtl/stacked_regfile_rdport.sv - one combinational read port with x0 masking and optional bypass
// Optional feature macro: STACKED_REGFILE_WRITE_BYPASS_EN (forward i_w_data on address match)
module stacked_regfile_rdport
   import stacked_regfile_pkg::*;
#(
   parameter int WIDTH  = WIDTH_C,
   parameter int ADDR_W = ADDR_W_C
) (
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic [WIDTH-1:0]  i_rd_raw,
   input  logic              i_w_ena,
   input  logic [ADDR_W-1:0] i_w_addr,
   input  logic [WIDTH-1:0]  i_w_data,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic addr_is_zero;

   assign addr_is_zero = (i_rd_addr == '0);

`ifdef STACKED_REGFILE_WRITE_BYPASS_EN
   logic bypass_hit;

   // A write landing on this address this cycle is forwarded so the consumer sees it with zero latency
   always_comb begin
      bypass_hit = i_w_ena && i_reset && (i_w_addr == i_rd_addr) && !addr_is_zero;
      o_rd_data  = '0;
      if (addr_is_zero) begin
         o_rd_data = '0;
      end else if (bypass_hit) begin
         o_rd_data = i_w_data;
      end else begin
         o_rd_data = i_rd_raw;
      end
   end
`else
   // Write-side inputs only matter for forwarding; sink them so the port stays uniform across builds
   logic unused_wr_sink;
   assign unused_wr_sink = &{1'b0, i_reset, i_w_ena, i_w_addr, i_w_data};

   // Stored value is shown until the write edge; x0 always reads zero
   always_comb begin
      o_rd_data = '0;
      if (!addr_is_zero) begin
         o_rd_data = i_rd_raw;
      end
   end
`endif

endmodule

// File: rtl/stacked_regfile.sv
// rtl/stacked_regfile.sv - 32x32 integer register file, two read ports, one write port
// Optional feature macro: STACKED_REGFILE_WRITE_BYPASS_EN (write-to-read forwarding in the read ports)
module stacked_regfile
   import stacked_regfile_pkg::*;
#(
   parameter int WIDTH  = WIDTH_C,
   parameter int ADDR_W = ADDR_W_C
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic              i_w_ena,
   input  logic [ADDR_W-1:0] i_w_addr,
   input  logic [WIDTH-1:0]  i_w_data,
   output logic [WIDTH-1:0]  o_a_data,
   output logic [WIDTH-1:0]  o_b_data
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [WIDTH-1:0] a_raw;
   logic [WIDTH-1:0] b_raw;

   // Next-state of the array: only the addressed register changes, and x0 never takes a write
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (i_w_ena && (i_w_addr != '0)) begin
         regs_d[i_w_addr] = i_w_data;
      end
   end

   // Storage: asynchronous clear dominates, so writes are lost while reset is held
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Raw array lookup for each port; masking and forwarding happen in the port modules
   always_comb begin
      a_raw = regs_q[i_a_addr];
      b_raw = regs_q[i_b_addr];
   end

   stacked_regfile_rdport #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_rdport_a (
      .i_reset   (i_reset),
      .i_rd_addr (i_a_addr),
      .i_rd_raw  (a_raw),
      .i_w_ena   (i_w_ena),
      .i_w_addr  (i_w_addr),
      .i_w_data  (i_w_data),
      .o_rd_data (o_a_data)
   );

   stacked_regfile_rdport #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_rdport_b (
      .i_reset   (i_reset),
      .i_rd_addr (i_b_addr),
      .i_rd_raw  (b_raw),
      .i_w_ena   (i_w_ena),
      .i_w_addr  (i_w_addr),
      .i_w_data  (i_w_data),
      .o_rd_data (o_b_data)
   );

endmodule

// File: tb/tb_stacked_regfile.sv
// tb/tb_stacked_regfile.sv - directed self-checking bench for stacked_regfile
// Optional feature macro: STACKED_REGFILE_WRITE_BYPASS_EN (changes the same-cycle hazard expectation)
module tb_stacked_regfile;

   logic        i_clk;
   logic        i_reset;
   logic [4:0]  i_a_addr;
   logic [4:0]  i_b_addr;
   logic        i_w_ena;
   logic [4:0]  i_w_addr;
   logic [31:0] i_w_data;
   logic [31:0] o_a_data;
   logic [31:0] o_b_data;

   int checks;
   int errors;

   stacked_regfile dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_a_addr (i_a_addr),
      .i_b_addr (i_b_addr),
      .i_w_ena  (i_w_ena),
      .i_w_addr (i_w_addr),
      .i_w_data (i_w_data),
      .o_a_data (o_a_data),
      .o_b_data (o_b_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      i_w_ena  = 1'b1;
      i_w_addr = addr;
      i_w_data = data;
      tick();
      i_w_ena  = 1'b0;
   endtask

   logic [31:0] hazard_exp;

   initial begin
      checks   = 0;
      errors   = 0;
      i_reset  = 1'b0;
      i_a_addr = '0;
      i_b_addr = '0;
      i_w_ena  = 1'b0;
      i_w_addr = '0;
      i_w_data = '0;

      // reset held for a clock: every address reads zero on both ports
      tick();
      for (int a = 0; a < 32; a++) begin
         i_a_addr = 5'(a);
         i_b_addr = 5'(31 - a);
         #1;
         check_eq("reset_a", o_a_data, 32'd0);
         check_eq("reset_b", o_b_data, 32'd0);
      end
      i_reset = 1'b1;
      tick();

      // x0 write is dropped
      wr(5'd0, 32'd10);
      i_a_addr = 5'd0;
      i_b_addr = 5'd0;
      #1;
      check_eq("x0_a", o_a_data, 32'd0);
      check_eq("x0_b", o_b_data, 32'd0);

      // basic write then read
      wr(5'd1, 32'd100);
      i_a_addr = 5'd1;
      #1;
      check_eq("x1_a", o_a_data, 32'd100);

      wr(5'd2, 32'd1000);
      i_b_addr = 5'd2;
      #1;
      check_eq("x2_b", o_b_data, 32'd1000);
      check_eq("x1_a_hold", o_a_data, 32'd100);

      // full-width pattern at the top address
      wr(5'd31, 32'hFFFF_FFFF);
      i_a_addr = 5'd31;
      #1;
      check_eq("x31_a", o_a_data, 32'hFFFF_FFFF);

      // write enable low: no change over two edges
      i_w_ena  = 1'b0;
      i_w_addr = 5'd2;
      i_w_data = 32'd2000;
      tick();
      tick();
      i_b_addr = 5'd2;
      #1;
      check_eq("wdis_b", o_b_data, 32'd1000);

      // both ports on the same register
      i_a_addr = 5'd2;
      i_b_addr = 5'd2;
      #1;
      check_eq("same_a", o_a_data, 32'd1000);
      check_eq("same_b", o_b_data, 32'd1000);

      // asynchronous reset between edges clears immediately
      i_a_addr = 5'd1;
      i_b_addr = 5'd2;
      #1;
      i_reset = 1'b0;
      #1;
      check_eq("areset_a", o_a_data, 32'd0);
      check_eq("areset_b", o_b_data, 32'd0);

      // write attempted while reset is low is ignored
      i_w_ena  = 1'b1;
      i_w_addr = 5'd3;
      i_w_data = 32'd55;
      tick();
      i_w_ena = 1'b0;
      i_reset = 1'b1;
      tick();
      #1;
      check_eq("post_rst_x1", o_a_data, 32'd0);
      check_eq("post_rst_x2", o_b_data, 32'd0);
      i_a_addr = 5'd3;
      i_b_addr = 5'd31;
      #1;
      check_eq("rst_wr_x3", o_a_data, 32'd0);
      check_eq("post_rst_x31", o_b_data, 32'd0);

      // same-cycle read/write hazard on x5
`ifdef STACKED_REGFILE_WRITE_BYPASS_EN
      hazard_exp = 32'd7;
`else
      hazard_exp = 32'd0;
`endif
      i_a_addr = 5'd5;
      i_b_addr = 5'd6;
      i_w_ena  = 1'b1;
      i_w_addr = 5'd5;
      i_w_data = 32'd7;
      #1;
      check_eq("hazard_a", o_a_data, hazard_exp);
      check_eq("hazard_b_other", o_b_data, 32'd0);
      tick();
      i_w_ena = 1'b0;
      #1;
      check_eq("hazard_after", o_a_data, 32'd7);

      // x0 never forwarded even with a matching write address
      i_a_addr = 5'd0;
      i_w_ena  = 1'b1;
      i_w_addr = 5'd0;
      i_w_data = 32'd99;
      #1;
      check_eq("x0_nofwd", o_a_data, 32'd0);
      tick();
      i_w_ena = 1'b0;
      #1;
      check_eq("x0_after", o_a_data, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
